// File: rtl/memory_interface.sv
// memory_interface: MAR/MDR holder turning control strobes into req/ack memory transactions
// Ports: clk, rst (sync, active high); bus, mar_in, mdr_in, mdr_out from control;
//   bus_out/bus_oe toward the shared bus; ready, overrun, timeout status;
//   mem_addr, mem_wdata, mem_req, mem_we, mem_rdata, mem_ack to external memory.
// Define MEM_TIMEOUT_EN to abandon a transaction after TIMEOUT_CYCLES cycles without mem_ack.
module memory_interface #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              mdr_out,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              ready,
    output logic              overrun,
    output logic              timeout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic idle, expire;
    assign idle = (state == IDLE);
`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    // expire fires on the last allowed cycle only when ack is absent, so a terminal-cycle ack wins
    assign expire = !idle && !mem_ack && (cnt == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk)
        if (rst || idle) cnt <= '0;
        else if (!mem_ack) cnt <= cnt + 1'b1;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif
    always_comb begin
        state_n = state;
        state_n = idle ? (mdr_in ? WRITE : (mar_in ? READ : IDLE)) : ((mem_ack || expire) ? IDLE : state);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mar     <= '0;
            mdr     <= '0;
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state <= state_n;
            if (idle && mar_in) mar <= bus[ADDR_W-1:0];
            if (idle && mdr_in) mdr <= bus;
            else if (state == READ && mem_ack) mdr <= mem_rdata;
            if (!idle && (mar_in || mdr_in || mdr_out)) overrun <= 1'b1;
            if (expire) timeout <= 1'b1;
        end
    end
    assign ready     = idle;
    assign mem_req   = !idle;
    assign mem_we    = (state == WRITE);
    assign mem_addr  = mar;
    assign mem_wdata = mdr;
    assign bus_out   = mdr;
    assign bus_oe    = mdr_out && idle;
endmodule
